// File: rtl/tcm_port_arb.sv
// Two-requester round-robin arbiter for a single-port TCM SRAM with bounded burst locking
// and one-cycle response routing back to the winning requester.
module tcm_port_arb #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_LOCK   = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    r0_req,
    input  logic                    r0_lock,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic                    r0_wr_en,
    input  logic [DATA_WIDTH-1:0]   r0_wr_data,
    input  logic [DATA_WIDTH/8-1:0] r0_wr_byte_en,
    output logic                    r0_gnt,
    output logic                    r0_rsp_vld,
    output logic [DATA_WIDTH-1:0]   r0_rd_data,

    input  logic                    r1_req,
    input  logic                    r1_lock,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic                    r1_wr_en,
    input  logic [DATA_WIDTH-1:0]   r1_wr_data,
    input  logic [DATA_WIDTH/8-1:0] r1_wr_byte_en,
    output logic                    r1_gnt,
    output logic                    r1_rsp_vld,
    output logic [DATA_WIDTH-1:0]   r1_rd_data,

    output logic                    mem_en,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_byte_en,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,

    output logic                    lock_timeout
);

    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam int unsigned CntW = $clog2(MAX_LOCK);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LOCK - 1);

    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rsp_vld_q, rsp_id_q, rsp_rd_q;

    logic              gnt0, gnt1, timeout, prio, lock_owner;
    logic              g0, g1;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        prio       = rr_q;
        lock_owner = (state_q == StLock1);
        timeout    = (state_q != StIdle) && (cnt_q == CntMax);

        if (state_q == StIdle || timeout) begin
            // On timeout the cycle is arbitrated as idle, favouring the starved side.
            prio = timeout ? ~lock_owner : rr_q;
            if (r0_req && r1_req) begin
                gnt0 = ~prio;
                gnt1 = prio;
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
            if (gnt0 || gnt1) begin
                rr_d = gnt0;
            end
            state_d = StIdle;
            cnt_d   = '0;
            if (!timeout) begin
                if (gnt0 && r0_lock) begin
                    state_d = StLock0;
                end else if (gnt1 && r1_lock) begin
                    state_d = StLock1;
                end
            end
        end else begin
            cnt_d = cnt_q + CntW'(1);
            if (lock_owner) begin
                gnt1 = r1_req;
                if (r1_req && !r1_lock) begin
                    state_d = StIdle;
                end
            end else begin
                gnt0 = r0_req;
                if (r0_req && !r0_lock) begin
                    state_d = StIdle;
                end
            end
        end
    end

    // Grants are combinational, so hold them low while reset is asserted.
    assign g0           = gnt0 & ~rst;
    assign g1           = gnt1 & ~rst;
    assign r0_gnt       = g0;
    assign r1_gnt       = g1;
    assign lock_timeout = timeout & ~rst;

    always_comb begin
        mem_en         = g0 | g1;
        mem_wr_en      = 1'b0;
        mem_addr       = '0;
        mem_wr_data    = '0;
        mem_wr_byte_en = '0;
        if (g0) begin
            mem_wr_en      = r0_wr_en;
            mem_addr       = r0_addr;
            mem_wr_data    = r0_wr_data;
            mem_wr_byte_en = r0_wr_byte_en & {BeW{r0_wr_en}};
        end else if (g1) begin
            mem_wr_en      = r1_wr_en;
            mem_addr       = r1_addr;
            mem_wr_data    = r1_wr_data;
            mem_wr_byte_en = r1_wr_byte_en & {BeW{r1_wr_en}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            rr_q      <= 1'b0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_id_q  <= 1'b0;
            rsp_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            rsp_vld_q <= g0 | g1;
            rsp_id_q  <= g1;
            rsp_rd_q  <= (g0 | g1) & ~mem_wr_en;
        end
    end

    assign r0_rsp_vld = rsp_vld_q & ~rsp_id_q;
    assign r1_rsp_vld = rsp_vld_q & rsp_id_q;
    assign r0_rd_data = (r0_rsp_vld && rsp_rd_q) ? mem_rd_data : '0;
    assign r1_rd_data = (r1_rsp_vld && rsp_rd_q) ? mem_rd_data : '0;

endmodule

// File: tb/tb_tcm_port_arb.sv
// Directed self-checking bench for tcm_port_arb with a behavioural 1-cycle-latency SRAM.
module tb_tcm_port_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned ML = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req, r0_lock, r0_wr_en, r1_req, r1_lock, r1_wr_en;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wr_data, r1_wr_data;
    logic [3:0]    r0_wr_byte_en, r1_wr_byte_en;
    logic          r0_gnt, r0_rsp_vld, r1_gnt, r1_rsp_vld;
    logic [DW-1:0] r0_rd_data, r1_rd_data;
    logic          mem_en, mem_wr_en, lock_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;
    logic [3:0]    mem_wr_byte_en;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tcm_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_wr_en(r0_wr_en),
        .r0_wr_data(r0_wr_data), .r0_wr_byte_en(r0_wr_byte_en), .r0_gnt(r0_gnt),
        .r0_rsp_vld(r0_rsp_vld), .r0_rd_data(r0_rd_data),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_wr_en(r1_wr_en),
        .r1_wr_data(r1_wr_data), .r1_wr_byte_en(r1_wr_byte_en), .r1_gnt(r1_gnt),
        .r1_rsp_vld(r1_rsp_vld), .r1_rd_data(r1_rd_data),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_byte_en(mem_wr_byte_en),
        .mem_rd_data(mem_rd_data), .lock_timeout(lock_timeout)
    );

    // Unwritten words read back a fixed pattern; word 8 starts at zero.
    function automatic logic [31:0] memval(input int idx);
        return (idx == 8) ? 32'h0 : (32'hC0DE_0000 | 32'(idx));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] wmem [64];
    logic [63:0] wvld;
    logic [5:0]  midx;
    assign midx = mem_addr[7:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wvld <= '0;
        end else if (mem_en) begin
            if (mem_wr_en) begin
                wmem[midx] <= merge(wvld[midx] ? wmem[midx] : memval(int'(midx)),
                                    mem_wr_data, mem_wr_byte_en);
                wvld[midx] <= 1'b1;
            end else begin
                mem_rd_data <= wvld[midx] ? wmem[midx] : memval(int'(midx));
            end
        end
    end

    task automatic drv0(input logic req, input logic lock, input logic [31:0] addr,
                        input logic wr, input logic [31:0] data, input logic [3:0] be);
        r0_req = req; r0_lock = lock; r0_addr = addr;
        r0_wr_en = wr; r0_wr_data = data; r0_wr_byte_en = be;
    endtask

    task automatic drv1(input logic req, input logic lock, input logic [31:0] addr,
                        input logic wr, input logic [31:0] data, input logic [3:0] be);
        r1_req = req; r1_lock = lock; r1_addr = addr;
        r1_wr_en = wr; r1_wr_data = data; r1_wr_byte_en = be;
    endtask

    task automatic idle_all();
        drv0(0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] v;
        #1;
        v = {r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, mem_en, lock_timeout};
        checks++; if (v !== 6'b0) begin errors++; $display("FAIL reset_outputs: got %b want 000000", v); end
        @(negedge clk);
        rst = 1'b0;
        drv0(1, 1, 32'h4, 0, 0, 0);
        #1;
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL reset_first_gnt: got %b want 1", r0_gnt); end
        @(negedge clk);
        #1;
        checks++; if (r0_rsp_vld !== 1'b1) begin errors++; $display("FAIL reset_pre_rsp: got %b want 1", r0_rsp_vld); end
        rst = 1'b1;
        #1;
        v = {r0_gnt, r1_gnt, r0_rsp_vld, r1_rsp_vld, mem_en, lock_timeout};
        checks++; if (v !== 6'b0) begin errors++; $display("FAIL reset_midcycle: got %b want 000000", v); end
        checks++; if ({r0_rd_data, mem_addr} !== 64'h0) begin errors++; $display("FAIL reset_data_zero: got %h want 0", {r0_rd_data, mem_addr}); end
        @(negedge clk);
        rst = 1'b0;
        drv0(1, 0, 32'hC, 0, 0, 0);
        #1;
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL reset_after_gnt: got %b want 1", r0_gnt); end
        checks++; if (r0_rsp_vld !== 1'b0) begin errors++; $display("FAIL reset_dropped_rsp: got %b want 0", r0_rsp_vld); end
        @(negedge clk);
        drv0(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if (r0_rsp_vld !== 1'b1) begin errors++; $display("FAIL reset_after_rsp: got %b want 1", r0_rsp_vld); end
        checks++; if (r0_rd_data !== 32'hC0DE0003) begin errors++; $display("FAIL reset_after_data: got %h want C0DE0003", r0_rd_data); end
    endtask

    task automatic test_round_robin();
        do_reset();
        drv0(1, 0, 32'h4, 0, 0, 0);
        drv1(1, 0, 32'h8, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if ({r0_gnt, r1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b%b want %s", i, r0_gnt, r1_gnt, (i % 2 == 0) ? "10" : "01"); end
            if (i > 0) begin
                if (i % 2 == 1) begin
                    checks++; if (r0_rsp_vld !== 1'b1 || r1_rsp_vld !== 1'b0 || r0_rd_data !== 32'hC0DE0001) begin errors++; $display("FAIL rr_rsp0[%0d]: got vld %b/%b data %h want 1/0 C0DE0001", i, r0_rsp_vld, r1_rsp_vld, r0_rd_data); end
                end else begin
                    checks++; if (r1_rsp_vld !== 1'b1 || r0_rsp_vld !== 1'b0 || r1_rd_data !== 32'hC0DE0002) begin errors++; $display("FAIL rr_rsp1[%0d]: got vld %b/%b data %h want 1/0 C0DE0002", i, r1_rsp_vld, r0_rsp_vld, r1_rd_data); end
                end
            end
            @(negedge clk);
        end
        idle_all();
        #1;
        checks++; if (r1_rsp_vld !== 1'b1 || r1_rd_data !== 32'hC0DE0002) begin errors++; $display("FAIL rr_last_rsp: got %b %h want 1 C0DE0002", r1_rsp_vld, r1_rd_data); end
    endtask

    task automatic test_burst_lock();
        do_reset();
        drv0(1, 0, 32'h0, 0, 0, 0);
        #1;
        checks++; if (r0_gnt !== 1'b1) begin errors++; $display("FAIL burst_pre_gnt: got %b want 1", r0_gnt); end
        @(negedge clk);
        drv1(1, 1, 32'h10, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt, lock_timeout} !== 3'b010 || mem_addr !== 32'h10) begin errors++; $display("FAIL burst_beat1: got %b%b%b addr %h want 010 addr 10", r0_gnt, r1_gnt, lock_timeout, mem_addr); end
        @(negedge clk);
        drv1(1, 1, 32'h14, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt, lock_timeout} !== 3'b010 || r1_rd_data !== 32'hC0DE0004) begin errors++; $display("FAIL burst_beat2: got %b%b%b data %h want 010 C0DE0004", r0_gnt, r1_gnt, lock_timeout, r1_rd_data); end
        @(negedge clk);
        drv1(1, 0, 32'h18, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt, lock_timeout} !== 3'b010 || r1_rd_data !== 32'hC0DE0005) begin errors++; $display("FAIL burst_beat3: got %b%b%b data %h want 010 C0DE0005", r0_gnt, r1_gnt, lock_timeout, r1_rd_data); end
        @(negedge clk);
        drv1(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt, lock_timeout} !== 3'b100 || r1_rd_data !== 32'hC0DE0006) begin errors++; $display("FAIL burst_release: got %b%b%b data %h want 100 C0DE0006", r0_gnt, r1_gnt, lock_timeout, r1_rd_data); end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_timeout();
        do_reset();
        drv0(1, 1, 32'h24, 0, 0, 0);
        drv1(1, 0, 32'h28, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({r0_gnt, r1_gnt, lock_timeout} !== ((i < 4) ? 3'b100 : 3'b011)) begin errors++; $display("FAIL timeout_cycle[%0d]: got %b%b%b want %s", i, r0_gnt, r1_gnt, lock_timeout, (i < 4) ? "100" : "011"); end
            @(negedge clk);
        end
        idle_all();
        #1;
        checks++; if (lock_timeout !== 1'b0 || r1_rsp_vld !== 1'b1 || r1_rd_data !== 32'hC0DE000A) begin errors++; $display("FAIL timeout_after: got to %b vld %b data %h want 0 1 C0DE000A", lock_timeout, r1_rsp_vld, r1_rd_data); end
    endtask

    task automatic test_write_read();
        do_reset();
        drv0(1, 0, 32'h20, 1, 32'hDEADBEEF, 4'b0011);
        #1;
        checks++; if ({mem_en, mem_wr_en} !== 2'b11 || mem_wr_byte_en !== 4'b0011 || mem_wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_drive: got %b%b be %b data %h want 11 0011 DEADBEEF", mem_en, mem_wr_en, mem_wr_byte_en, mem_wr_data); end
        @(negedge clk);
        drv0(0, 0, 0, 0, 0, 0);
        drv1(1, 0, 32'h20, 0, 32'h12345678, 4'hF);
        #1;
        checks++; if ({r1_gnt, mem_wr_en} !== 2'b10 || mem_wr_byte_en !== 4'b0000) begin errors++; $display("FAIL rd_drive: got gnt %b we %b be %b want 1 0 0000", r1_gnt, mem_wr_en, mem_wr_byte_en); end
        checks++; if (r0_rsp_vld !== 1'b1 || r0_rd_data !== 32'h0) begin errors++; $display("FAIL wr_rsp: got %b %h want 1 0", r0_rsp_vld, r0_rd_data); end
        @(negedge clk);
        idle_all();
        #1;
        checks++; if (r1_rsp_vld !== 1'b1 || r1_rd_data !== 32'h0000BEEF) begin errors++; $display("FAIL rd_rsp: got %b %h want 1 0000BEEF", r1_rsp_vld, r1_rd_data); end
        checks++; if (r0_rsp_vld !== 1'b0 || r0_rd_data !== 32'h0) begin errors++; $display("FAIL rd_other_quiet: got %b %h want 0 0", r0_rsp_vld, r0_rd_data); end
    endtask

    task automatic test_idle_lock();
        do_reset();
        drv0(1, 1, 32'h30, 0, 0, 0);
        drv1(1, 0, 32'h34, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL idlelock_enter: got %b%b want 10", r0_gnt, r1_gnt); end
        @(negedge clk);
        drv0(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({r1_gnt, mem_en} !== 2'b00 || mem_addr !== 32'h0) begin errors++; $display("FAIL idlelock_hold[%0d]: got gnt %b en %b addr %h want 0 0 0", i, r1_gnt, mem_en, mem_addr); end
            @(negedge clk);
        end
        drv0(1, 0, 32'h30, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt} !== 2'b10) begin errors++; $display("FAIL idlelock_end: got %b%b want 10", r0_gnt, r1_gnt); end
        @(negedge clk);
        drv0(0, 0, 0, 0, 0, 0);
        #1;
        checks++; if ({r0_gnt, r1_gnt} !== 2'b01) begin errors++; $display("FAIL idlelock_other: got %b%b want 01", r0_gnt, r1_gnt); end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_timeout();
        test_write_read();
        test_idle_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
